// File: rtl/palette_fade_lut_if.sv
// Bus bundle for palette_fade_lut: palette write port, pipelined lookup
// request/response, and fade engine control/status.
interface palette_fade_lut_if #(
    parameter int INDEX_W = 4,
    parameter int CH_W    = 4,
    parameter int LEVEL_W = 4
);
    logic               wr_en;
    logic [INDEX_W-1:0] wr_index;
    logic [3*CH_W-1:0]  wr_rgb;
    logic               rd_valid_in;
    logic [INDEX_W-1:0] index;
    logic               fade_start;
    logic               fade_dir;
    logic [CH_W-1:0]    red;
    logic [CH_W-1:0]    green;
    logic [CH_W-1:0]    blue;
    logic               rd_valid_out;
    logic               transparent;
    logic               fade_busy;
    logic [LEVEL_W:0]   fade_level;

    modport master (
        output wr_en, wr_index, wr_rgb, rd_valid_in, index, fade_start, fade_dir,
        input  red, green, blue, rd_valid_out, transparent, fade_busy, fade_level
    );

    modport slave (
        input  wr_en, wr_index, wr_rgb, rd_valid_in, index, fade_start, fade_dir,
        output red, green, blue, rd_valid_out, transparent, fade_busy, fade_level
    );
endinterface

// File: rtl/palette_fade_lut.sv
// Runtime-writable RGB palette with a 2-stage lookup pipeline, transparency
// flag and a timed global brightness fade (fade-in / fade-out).
module palette_fade_lut #(
    parameter int INDEX_W         = 4,
    parameter int CH_W            = 4,
    parameter int LEVEL_W         = 4,
    parameter int FADE_DIV        = 65536,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    palette_fade_lut_if.slave   bus
);
    localparam int DEPTH  = 1 << INDEX_W;
    localparam int RGB_W  = 3 * CH_W;
    localparam int PROD_W = CH_W + LEVEL_W + 1;
    localparam int CNT_W  = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [LEVEL_W:0]   LVL_FULL  = {1'b1, {LEVEL_W{1'b0}}};
    localparam logic [LEVEL_W:0]   LVL_ZERO  = {(LEVEL_W+1){1'b0}};
    localparam logic [LEVEL_W:0]   LVL_ONE   = {{LEVEL_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(FADE_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [INDEX_W-1:0] TRANSP_IX = INDEX_W'(TRANSPARENT_IDX);

    typedef enum logic [0:0] {
        FADE_IDLE = 1'b0,
        FADE_RUN  = 1'b1
    } fade_state_t;

    // Scale one channel by the brightness level; FULL is an exact identity.
    function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch,
                                                 input logic [LEVEL_W:0] lvl);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(ch) * PROD_W'(lvl);
        return prod[LEVEL_W +: CH_W];
    endfunction

    logic [RGB_W-1:0] palette_r [DEPTH];
    logic [RGB_W-1:0] lookup_rgb_s;

    logic [RGB_W-1:0] s1_rgb_r;
    logic             s1_valid_r;
    logic             s1_transp_r;

    logic [CH_W-1:0]  red_r;
    logic [CH_W-1:0]  green_r;
    logic [CH_W-1:0]  blue_r;
    logic             s2_valid_r;
    logic             s2_transp_r;

    fade_state_t      state_r;
    fade_state_t      state_nxt_s;
    logic             dir_r;
    logic [LEVEL_W:0] level_r;
    logic [CNT_W-1:0] cnt_r;
    logic             step_s;
    logic [LEVEL_W:0] level_step_s;
    logic             done_s;
    logic             fade_busy_s;

    // Palette storage: cleared on reset, one entry written per wr_en.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                palette_r[i] <= {RGB_W{1'b0}};
            end
        end else if (bus.wr_en) begin
            palette_r[bus.wr_index] <= bus.wr_rgb;
        end
    end

    // Write-first bypass: a same-cycle write to the looked-up entry wins.
    always_comb begin
        lookup_rgb_s = palette_r[bus.index];
        if (bus.wr_en && (bus.wr_index == bus.index)) begin
            lookup_rgb_s = bus.wr_rgb;
        end else begin
            lookup_rgb_s = palette_r[bus.index];
        end
    end

    // Stage 1: capture entry, valid and transparency compare.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_rgb_r    <= {RGB_W{1'b0}};
            s1_valid_r  <= 1'b0;
            s1_transp_r <= 1'b0;
        end else begin
            s1_rgb_r    <= lookup_rgb_s;
            s1_valid_r  <= bus.rd_valid_in;
            s1_transp_r <= (bus.index == TRANSP_IX);
        end
    end

    // Stage 2: apply the current brightness level to each channel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            red_r       <= {CH_W{1'b0}};
            green_r     <= {CH_W{1'b0}};
            blue_r      <= {CH_W{1'b0}};
            s2_valid_r  <= 1'b0;
            s2_transp_r <= 1'b0;
        end else begin
            red_r       <= scale_ch(s1_rgb_r[2*CH_W +: CH_W], level_r);
            green_r     <= scale_ch(s1_rgb_r[CH_W   +: CH_W], level_r);
            blue_r      <= scale_ch(s1_rgb_r[0      +: CH_W], level_r);
            s2_valid_r  <= s1_valid_r;
            s2_transp_r <= s1_transp_r;
        end
    end

    // Fade step decode: a level step happens on the last count of a period.
    always_comb begin
        step_s       = (state_r == FADE_RUN) && (cnt_r == CNT_LAST);
        level_step_s = dir_r ? (level_r + LVL_ONE) : (level_r - LVL_ONE);
        done_s       = step_s && (dir_r ? (level_step_s == LVL_FULL)
                                        : (level_step_s == LVL_ZERO));
    end

    // Fade FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= FADE_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fade FSM next state: start only from idle, stop on the final step.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            FADE_IDLE: begin
                if (bus.fade_start) begin
                    state_nxt_s = FADE_RUN;
                end else begin
                    state_nxt_s = FADE_IDLE;
                end
            end
            FADE_RUN: begin
                if (done_s) begin
                    state_nxt_s = FADE_IDLE;
                end else begin
                    state_nxt_s = FADE_RUN;
                end
            end
            default: state_nxt_s = FADE_IDLE;
        endcase
    end

    // Fade FSM outputs.
    always_comb begin
        fade_busy_s = (state_r == FADE_RUN);
    end

    // Fade datapath: direction, brightness level and step counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dir_r   <= 1'b0;
            level_r <= LVL_FULL;
            cnt_r   <= {CNT_W{1'b0}};
        end else if ((state_r == FADE_IDLE) && bus.fade_start) begin
            dir_r   <= bus.fade_dir;
            level_r <= bus.fade_dir ? LVL_ZERO : LVL_FULL;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (state_r == FADE_RUN) begin
            if (step_s) begin
                cnt_r   <= {CNT_W{1'b0}};
                level_r <= level_step_s;
            end else begin
                cnt_r   <= cnt_r + CNT_ONE;
            end
        end
    end

    assign bus.red          = red_r;
    assign bus.green        = green_r;
    assign bus.blue         = blue_r;
    assign bus.rd_valid_out = s2_valid_r;
    assign bus.transparent  = s2_transp_r;
    assign bus.fade_busy    = fade_busy_s;
    assign bus.fade_level   = level_r;
endmodule

// File: tb/tb_palette_fade_lut.sv
// Self-checking bench for palette_fade_lut: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_palette_fade_lut;
    localparam int INDEX_W  = 4;
    localparam int CH_W     = 4;
    localparam int LEVEL_W  = 4;
    localparam int FADE_DIV = 4;
    localparam int TIDX     = 0;
    localparam int FULL     = 16;

    logic Clk = 1'b0;
    logic Reset;

    palette_fade_lut_if #(.INDEX_W(INDEX_W), .CH_W(CH_W), .LEVEL_W(LEVEL_W)) bus ();

    palette_fade_lut #(
        .INDEX_W(INDEX_W), .CH_W(CH_W), .LEVEL_W(LEVEL_W),
        .FADE_DIV(FADE_DIV), .TRANSPARENT_IDX(TIDX)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_pal [16];
    int edges = 0;        // clock edges since the last reset
    bit started = 1'b0;   // a fade has been accepted since reset
    int t0 = 0;           // edge count right after the accepted fade_start
    bit mdir = 1'b0;
    bit p_valid, p_transp;
    int p_rgb;
    bit e_valid, e_transp;
    int e_r, e_g, e_b;
    bit model_live = 1'b0;

    // Brightness after n edges: one level per FADE_DIV cycles, clamped.
    function automatic int lvl_at(input int n);
        int steps;
        if (!started) return FULL;
        steps = (n - t0) / FADE_DIV;
        if (steps > FULL) steps = FULL;
        return mdir ? steps : FULL - steps;
    endfunction

    function automatic int busy_at(input int n);
        if (!started) return 0;
        return ((n - t0) / FADE_DIV < FULL) ? 1 : 0;
    endfunction

    always begin : model_p
        int lvl;
        @(posedge Clk);
        if (Reset) begin
            for (int i = 0; i < 16; i++) m_pal[i] = 0;
            edges = 0; started = 1'b0;
            p_valid = 1'b0; p_transp = 1'b0; p_rgb = 0;
            e_valid = 1'b0; e_transp = 1'b0; e_r = 0; e_g = 0; e_b = 0;
            model_live = 1'b1;
        end else if (model_live) begin
            lvl = lvl_at(edges);
            e_valid  = p_valid;
            e_transp = p_transp;
            e_r = ((p_rgb >> 8) & 15) * lvl / FULL;
            e_g = ((p_rgb >> 4) & 15) * lvl / FULL;
            e_b = (p_rgb & 15) * lvl / FULL;
            p_valid  = bus.rd_valid_in;
            p_transp = (int'(bus.index) == TIDX);
            if (bus.wr_en && (bus.wr_index == bus.index)) p_rgb = int'(bus.wr_rgb);
            else p_rgb = m_pal[bus.index];
            if (bus.wr_en) m_pal[bus.wr_index] = int'(bus.wr_rgb);
            if (bus.fade_start && (busy_at(edges) == 0)) begin
                started = 1'b1;
                mdir = bus.fade_dir;
                t0 = edges + 1;
            end
            edges++;
        end
    end

    // Compare DUT against the model on the falling edge.
    always begin : compare_p
        @(negedge Clk);
        if (model_live) begin
            check("m_rd_valid_out", int'(bus.rd_valid_out), int'(e_valid));
            check("m_fade_level", int'(bus.fade_level), lvl_at(edges));
            check("m_fade_busy", int'(bus.fade_busy), busy_at(edges));
            if (e_valid || (edges == 0)) begin
                check("m_red", int'(bus.red), e_r);
                check("m_green", int'(bus.green), e_g);
                check("m_blue", int'(bus.blue), e_b);
                check("m_transparent", int'(bus.transparent), int'(e_transp));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic int rgb_now();
        return int'({bus.red, bus.green, bus.blue});
    endfunction

    initial begin
        Reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_index = '0; bus.wr_rgb = '0;
        bus.rd_valid_in = 1'b0; bus.index = '0;
        bus.fade_start = 1'b0; bus.fade_dir = 1'b0;
        step(); step();
        Reset = 1'b0;
        check("reset_level", int'(bus.fade_level), 16);
        check("reset_busy", int'(bus.fade_busy), 0);
        check("reset_vout", int'(bus.rd_valid_out), 0);

        // Read idx5 then idx0 on an empty palette.
        bus.rd_valid_in = 1'b1; bus.index = 4'd5; step();
        bus.index = 4'd0; step();
        check("idx5_valid", int'(bus.rd_valid_out), 1);
        check("idx5_rgb", rgb_now(), 0);
        check("idx5_transp", int'(bus.transparent), 0);
        bus.rd_valid_in = 1'b0; step();
        check("idx0_transp", int'(bus.transparent), 1);

        // Write then read; same-cycle write/read bypass.
        bus.wr_en = 1'b1; bus.wr_index = 4'd3; bus.wr_rgb = 12'hFD1; step();
        bus.wr_en = 1'b0; bus.rd_valid_in = 1'b1; bus.index = 4'd3; step();
        bus.rd_valid_in = 1'b0; step();
        check("idx3_rgb", rgb_now(), 12'hFD1);
        bus.wr_en = 1'b1; bus.wr_index = 4'd7; bus.wr_rgb = 12'h7AD;
        bus.rd_valid_in = 1'b1; bus.index = 4'd7; step();
        bus.wr_en = 1'b0; bus.rd_valid_in = 1'b0; step();
        check("bypass_idx7", rgb_now(), 12'h7AD);

        // Valid pattern 1,0,1.
        bus.rd_valid_in = 1'b1; bus.index = 4'd3; step();
        bus.rd_valid_in = 1'b0; bus.index = 4'd7; step();
        check("pat_v0", int'(bus.rd_valid_out), 1);
        check("pat_rgb0", rgb_now(), 12'hFD1);
        bus.rd_valid_in = 1'b1; bus.index = 4'd3; step();
        check("pat_v1", int'(bus.rd_valid_out), 0);
        bus.rd_valid_in = 1'b0; step();
        check("pat_v2", int'(bus.rd_valid_out), 1);
        check("pat_rgb2", rgb_now(), 12'hFD1);

        // Fade out from FULL.
        bus.fade_start = 1'b1; bus.fade_dir = 1'b0; step();
        bus.fade_start = 1'b0;
        check("fout_busy", int'(bus.fade_busy), 1);
        check("fout_lvl0", int'(bus.fade_level), 16);
        repeat (3) step();
        check("fout_lvl3", int'(bus.fade_level), 16);
        step();
        check("fout_lvl4", int'(bus.fade_level), 15);
        repeat (28) step();
        check("fout_lvl32", int'(bus.fade_level), 8);
        bus.rd_valid_in = 1'b1; bus.index = 4'd3; step();
        bus.rd_valid_in = 1'b0; step();
        check("half_idx3", rgb_now(), 12'h760);
        repeat (29) step();
        check("fout_lvl63", int'(bus.fade_level), 1);
        check("fout_busy63", int'(bus.fade_busy), 1);
        step();
        check("fout_lvl64", int'(bus.fade_level), 0);
        check("fout_busy64", int'(bus.fade_busy), 0);
        bus.rd_valid_in = 1'b1; bus.index = 4'd3; step();
        bus.rd_valid_in = 1'b0; step();
        check("dark_idx3", rgb_now(), 0);

        // Fade in with an ignored restart in the middle.
        bus.fade_start = 1'b1; bus.fade_dir = 1'b1; step();
        bus.fade_start = 1'b0;
        check("fin_lvl0", int'(bus.fade_level), 0);
        check("fin_busy", int'(bus.fade_busy), 1);
        repeat (20) step();
        bus.fade_start = 1'b1; bus.fade_dir = 1'b0; step();
        bus.fade_start = 1'b0;
        check("fin_ignore", int'(bus.fade_level), 5);
        repeat (42) step();
        check("fin_lvl63", int'(bus.fade_level), 15);
        step();
        check("fin_lvl64", int'(bus.fade_level), 16);
        check("fin_busy64", int'(bus.fade_busy), 0);

        // Reset mid-fade at level 9 with a read in flight.
        bus.fade_start = 1'b1; bus.fade_dir = 1'b0; step();
        bus.fade_start = 1'b0;
        repeat (27) step();
        bus.rd_valid_in = 1'b1; bus.index = 4'd7; step();
        check("rst_pre_lvl", int'(bus.fade_level), 9);
        Reset = 1'b1; step();
        Reset = 1'b0; bus.rd_valid_in = 1'b0;
        check("rst_lvl", int'(bus.fade_level), 16);
        check("rst_busy", int'(bus.fade_busy), 0);
        check("rst_vout", int'(bus.rd_valid_out), 0);
        for (int i = 0; i < 16; i++) begin
            bus.rd_valid_in = 1'b1; bus.index = 4'(i); step();
            bus.rd_valid_in = 1'b0; step();
            check("rst_clear_rgb", rgb_now(), 0);
        end

        // Randomized traffic checked by the model.
        for (int c = 0; c < 1500; c++) begin
            bus.wr_en       = ($urandom_range(0, 3) == 0);
            bus.wr_index    = 4'($urandom_range(0, 15));
            bus.wr_rgb      = 12'($urandom());
            bus.rd_valid_in = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) bus.index = bus.wr_index;
            else bus.index = 4'($urandom_range(0, 15));
            bus.fade_start  = ($urandom_range(0, 99) == 0);
            bus.fade_dir    = ($urandom_range(0, 1) == 1);
            Reset           = ($urandom_range(0, 499) == 0);
            step();
        end
        Reset = 1'b0; bus.wr_en = 1'b0; bus.rd_valid_in = 1'b0; bus.fade_start = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
